// File: rtl/esn_loader_pkg.sv
// Shared constants and state encoding for the ESN weight loader.
// SEL codes select which core SRAM section a heap write targets.
package esn_loader_pkg;

   localparam logic [2:0] SEL_NONE = 3'd0;
   localparam logic [2:0] SEL_X    = 3'd1;
   localparam logic [2:0] SEL_W    = 3'd2;
   localparam logic [2:0] SEL_WIN  = 3'd3;
   localparam logic [2:0] SEL_WINB = 3'd4;
   localparam logic [2:0] SEL_WOUT = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ARM,
      RUN
   } state_t;

endpackage

// File: rtl/esn_section_counter.sv
// Word index / section tracker for the heap load sequence.
// Index wraps at node_num and bumps the section on each wrap.
module esn_section_counter
   import esn_loader_pkg::*;
#(
   parameter int node_num         = 1000,
   parameter int addr_length_heap = 10
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        clear,
   input  logic                        advance,
   output logic [2:0]                  section,
   output logic [addr_length_heap-1:0] index,
   output logic                        last_word
);

   localparam logic [addr_length_heap-1:0] LAST_IDX =
      addr_length_heap'(node_num - 1);

   always_ff @(posedge clk) begin
      if (nrst || clear) begin
         section <= SEL_X;
         index   <= '0;
      end else if (advance) begin
         if (index == LAST_IDX) begin
            index   <= '0;
            section <= section + 3'd1;
         end else begin
            index <= index + 1'b1;
         end
      end
   end

   assign last_word = (section == SEL_WOUT) && (index == LAST_IDX);

endmodule

// File: rtl/esn_weight_loader.sv
// Streams X/W/Win/Winb/Wout into the ESN core heap, then runs the core.
// Optional running word sum output enabled by ESN_LOADER_CKSUM_EN.
module esn_weight_loader
   import esn_loader_pkg::*;
#(
   parameter int bit_length       = 32,
   parameter int node_num         = 1000,
   parameter int addr_length_heap = 10
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        start,
   input  logic                        stop,
   input  logic [bit_length-1:0]       s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic [bit_length-1:0]       Data_in,
   output logic [addr_length_heap-1:0] addr_inSRAM_offchip,
   output logic [2:0]                  SEL_SRAM_input,
   output logic                        EN_system_n,
   output logic                        busy,
   output logic                        done
`ifdef ESN_LOADER_CKSUM_EN
   ,
   output logic [bit_length-1:0]       cksum
`endif
);

   state_t                        state;
   state_t                        next_state;
   logic                          beat;
   logic                          go;
   logic [2:0]                    section;
   logic [addr_length_heap-1:0]   index;
   logic                          last_word;

   assign s_ready = (state == LOAD) && !stop;
   assign beat    = s_valid && s_ready;
   assign go      = (state == IDLE) && start && !stop;

   esn_section_counter #(
      .node_num         (node_num),
      .addr_length_heap (addr_length_heap)
   ) u_cnt (
      .clk       (clk),
      .nrst      (nrst),
      .clear     (go),
      .advance   (beat),
      .section   (section),
      .index     (index),
      .last_word (last_word)
   );

   always_ff @(posedge clk) begin
      if (nrst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (go) next_state = LOAD;
         LOAD: begin
            if (stop)                   next_state = IDLE;
            else if (beat && last_word) next_state = ARM;
         end
         ARM:  next_state = RUN;
         RUN:  if (stop) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Status flags track the state being entered so they align with it.
   always_ff @(posedge clk) begin
      if (nrst) begin
         Data_in             <= '0;
         addr_inSRAM_offchip <= '0;
         SEL_SRAM_input      <= SEL_NONE;
         EN_system_n         <= 1'b1;
         busy                <= 1'b0;
         done                <= 1'b0;
      end else begin
         SEL_SRAM_input <= beat ? section : SEL_NONE;
         if (beat) begin
            Data_in             <= s_data;
            addr_inSRAM_offchip <= index;
         end
         EN_system_n <= (next_state != RUN);
         busy        <= (next_state == LOAD) || (next_state == ARM);
         done        <= (next_state == RUN);
      end
   end

`ifdef ESN_LOADER_CKSUM_EN
   always_ff @(posedge clk) begin
      if (nrst || go) cksum <= '0;
      else if (beat)  cksum <= cksum + s_data;
   end
`endif

endmodule

// File: tb/tb_esn_weight_loader.sv
// Scoreboard bench for esn_weight_loader with node_num=4.
// Define ESN_LOADER_CKSUM_EN to also cover the word sum output.
module tb_esn_weight_loader;

   localparam int BL = 32;
   localparam int NN = 4;
   localparam int AL = 2;
   localparam int TOTAL = 5 * NN;

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic          stop;
   logic [BL-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [BL-1:0] Data_in;
   logic [AL-1:0] addr_inSRAM_offchip;
   logic [2:0]    SEL_SRAM_input;
   logic          EN_system_n;
   logic          busy;
   logic          done;
`ifdef ESN_LOADER_CKSUM_EN
   logic [BL-1:0] cksum;
`endif

   esn_weight_loader #(
      .bit_length       (BL),
      .node_num         (NN),
      .addr_length_heap (AL)
   ) dut (
      .clk                 (clk),
      .nrst                (nrst),
      .start               (start),
      .stop                (stop),
      .s_data              (s_data),
      .s_valid             (s_valid),
      .s_ready             (s_ready),
      .Data_in             (Data_in),
      .addr_inSRAM_offchip (addr_inSRAM_offchip),
      .SEL_SRAM_input      (SEL_SRAM_input),
      .EN_system_n         (EN_system_n),
      .busy                (busy),
      .done                (done)
`ifdef ESN_LOADER_CKSUM_EN
      ,
      .cksum               (cksum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]    sel;
      logic [AL-1:0] addr;
      logic [BL-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   int            n_cmp  = 0;
   int            n_bad  = 0;
   int            wr_cnt = 0;
   int            beat_k = 0;
   logic [BL-1:0] m_sum  = '0;

   function automatic wr_t model_wr(input int k, input logic [BL-1:0] d);
      wr_t w;
      w.sel  = 3'(k / NN + 1);
      w.addr = AL'(k % NN);
      w.data = d;
      return w;
   endfunction

   // Every presented heap write must match the next expected one.
   always @(posedge clk) begin
      wr_t e;
      #1;
      if (SEL_SRAM_input !== 3'd0) begin
         wr_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write got sel=%0d addr=%0d data=%h",
                     SEL_SRAM_input, addr_inSRAM_offchip, Data_in);
         end else begin
            e = exp_q.pop_front();
            if ({SEL_SRAM_input, addr_inSRAM_offchip, Data_in} !== e) begin
               n_bad++;
               $display("FAIL heap_write got sel=%0d addr=%0d data=%h want sel=%0d addr=%0d data=%h",
                        SEL_SRAM_input, addr_inSRAM_offchip, Data_in,
                        e.sel, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic drive(input logic v, input logic [BL-1:0] d,
                        input logic st, input logic sp, input logic exp_beat);
      @(negedge clk);
      s_valid = v;
      s_data  = d;
      start   = st;
      stop    = sp;
      if (exp_beat) begin
         exp_q.push_back(model_wr(beat_k, d));
         beat_k++;
         m_sum += d;
      end
   endtask

   task automatic test_reset;
      nrst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({s_ready, Data_in, addr_inSRAM_offchip, SEL_SRAM_input,
           EN_system_n, busy, done} !== {1'b0, 32'h0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_values got rdy=%b d=%h a=%0d sel=%0d en_n=%b busy=%b done=%b want 0 0 0 0 1 0 0",
                  s_ready, Data_in, addr_inSRAM_offchip, SEL_SRAM_input,
                  EN_system_n, busy, done);
      end
      nrst = 1'b0;
      exp_q.delete();
      beat_k = 0;
   endtask

   task automatic begin_load;
      int w0;
      w0 = wr_cnt;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      beat_k = 0;
      m_sum  = '0;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || EN_system_n !== 1'b1) begin
         n_bad++;
         $display("FAIL start_load got busy=%b en_n=%b want 1 1", busy, EN_system_n);
      end
`ifdef ESN_LOADER_CKSUM_EN
      n_cmp++;
      if (cksum !== '0) begin
         n_bad++;
         $display("FAIL cksum_clear got %h want 0", cksum);
      end
`endif
   endtask

   task automatic test_stream(input bit gap);
      int w0;
      begin_load();
      w0 = wr_cnt;
      for (int k = 0; k < TOTAL; k++) begin
         drive(1'b1, BL'(k + 1), 1'b0, 1'b0, 1'b1);
         #1;
         n_cmp++;
         if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL s_ready_load k=%0d got %b want 1", k, s_ready);
         end
         if (gap) begin
            drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #2;
            n_cmp++;
            if (SEL_SRAM_input !== 3'd0) begin
               n_bad++;
               $display("FAIL gap_sel k=%0d got %0d want 0", k, SEL_SRAM_input);
            end
         end
      end
      if (!gap) begin
         @(negedge clk);
         s_valid = 1'b0;
         n_cmp++;
         if ({busy, done, EN_system_n, s_ready} !== 4'b1010) begin
            n_bad++;
            $display("FAIL arm_state got busy=%b done=%b en_n=%b rdy=%b want 1 0 1 0",
                     busy, done, EN_system_n, s_ready);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done, EN_system_n, s_ready} !== 4'b0100) begin
         n_bad++;
         $display("FAIL run_state got busy=%b done=%b en_n=%b rdy=%b want 0 1 0 0",
                  busy, done, EN_system_n, s_ready);
      end
      n_cmp++;
      if (wr_cnt - w0 !== TOTAL || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL write_count got %0d pending=%0d want %0d pending=0",
                  wr_cnt - w0, exp_q.size(), TOTAL);
      end
`ifdef ESN_LOADER_CKSUM_EN
      n_cmp++;
      if (cksum !== m_sum) begin
         n_bad++;
         $display("FAIL cksum_run got %h want %h", cksum, m_sum);
      end
`endif
   endtask

   task automatic test_run_stop;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (EN_system_n !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL run_ignore_start got en_n=%b done=%b busy=%b want 0 1 0",
                  EN_system_n, done, busy);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_cmp++;
      if (EN_system_n !== 1'b1 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL run_stop got en_n=%b done=%b want 1 0", EN_system_n, done);
      end
   endtask

   task automatic test_start_stop_idle;
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || EN_system_n !== 1'b1) begin
         n_bad++;
         $display("FAIL idle_stop_wins got busy=%b en_n=%b want 0 1", busy, EN_system_n);
      end
   endtask

   task automatic test_stop_abort;
      begin_load();
      for (int k = 0; k < 7; k++)
         drive(1'b1, BL'(k + 1), 1'b0, 1'b0, 1'b1);
      drive(1'b1, BL'(8), 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (s_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL stop_ready got %b want 0", s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
      stop    = 1'b0;
      n_cmp++;
      if ({busy, done, EN_system_n, SEL_SRAM_input} !== {3'b001, 3'd0}) begin
         n_bad++;
         $display("FAIL stop_idle got busy=%b done=%b en_n=%b sel=%0d want 0 0 1 0",
                  busy, done, EN_system_n, SEL_SRAM_input);
      end
      begin_load();
      drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      stop = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_write got pending=%0d busy=%b want 0 0", exp_q.size(), busy);
      end
   endtask

   task automatic test_reset_midload;
      begin_load();
      for (int k = 0; k < 9; k++)
         drive(1'b1, BL'(k + 1), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      nrst    = 1'b1;
      s_valid = 1'b1;
      s_data  = BL'(10);
      @(negedge clk);
      n_cmp++;
      if ({s_ready, Data_in, addr_inSRAM_offchip, SEL_SRAM_input,
           EN_system_n, busy, done} !== {1'b0, 32'h0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL midload_reset got rdy=%b d=%h a=%0d sel=%0d en_n=%b busy=%b done=%b want 0 0 0 0 1 0 0",
                  s_ready, Data_in, addr_inSRAM_offchip, SEL_SRAM_input,
                  EN_system_n, busy, done);
      end
`ifdef ESN_LOADER_CKSUM_EN
      n_cmp++;
      if (cksum !== '0) begin
         n_bad++;
         $display("FAIL midload_cksum got %h want 0", cksum);
      end
`endif
      nrst    = 1'b0;
      s_valid = 1'b0;
      exp_q.delete();
      test_stream(1'b0);
   endtask

   initial begin
      test_reset();
      test_stream(1'b0);
      test_run_stop();
      test_start_stop_idle();
      test_stream(1'b1);
      test_run_stop();
      test_stop_abort();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
